// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [7:0] LED_OFS    = 8'h00;
    localparam logic [7:0] CYCLE_OFS  = 8'h04;
    localparam logic [7:0] STATUS_OFS = 8'h08;

    localparam int unsigned STATUS_DONE_BIT = 0;
    localparam int unsigned STATUS_PASS_BIT = 1;
    localparam int unsigned STATUS_ERR_BIT  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        DONE = 1'b1
    } done_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Core data port: store strobe, byte address, store data and load data.
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              MemWrite;
    logic [WORD_W-1:0] DataAdr;
    logic [WORD_W-1:0] WriteData;
    logic [WORD_W-1:0] ReadData;

    modport master (output MemWrite, output DataAdr, output WriteData, input ReadData);
    modport slave  (input MemWrite, input DataAdr, input WriteData, output ReadData);

endinterface

// File: rtl/dmem_ram.sv
// Word-addressed data RAM: synchronous write, asynchronous read, no reset.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: RAM, MMIO window (LED, cycle counter, status) and completion detector.
// Build option: DMEM_ALIGN_CHECK_EN drops misaligned stores and flags them in err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned       DEPTH      = 64,
    parameter logic [WORD_W-1:0] DONE_ADDR  = 32'd252,
    parameter logic [WORD_W-1:0] PASS_VALUE = 32'h0000_1000,
    parameter logic [WORD_W-1:0] MMIO_BASE  = 32'hFFFF_FF00
) (
    input  logic                    clk,
    input  logic                    reset,
    dmem_responder_if.slave         bus,
    output logic [7:0]              leds,
    output logic                    done,
    output logic                    pass,
    output logic                    err
);

    localparam int unsigned       AW        = $clog2(DEPTH);
    localparam logic [WORD_W-1:0] RAM_BYTES = WORD_W'(4 * DEPTH);

    logic              ram_hit_c, mmio_hit_c, misalign_c, done_hit_c;
    logic              ram_we_c, led_we_c, store_err_c;
    logic [7:0]        ofs_c;
    logic [AW-1:0]     word_idx_c;
    logic [WORD_W-1:0] ram_rdata, rdata_c;

    done_state_t       state_q, state_d;
    logic              pass_q, pass_d;
    logic              err_q, err_d;
    logic [7:0]        leds_q, leds_d;
    logic [WORD_W-1:0] cycle_q, cycle_d;

    // Address decode and store qualification
    always_comb begin
        ram_hit_c  = bus.DataAdr < RAM_BYTES;
        mmio_hit_c = bus.DataAdr[WORD_W-1:8] == MMIO_BASE[WORD_W-1:8];
        ofs_c      = bus.DataAdr[7:0];
        word_idx_c = bus.DataAdr[AW+1:2];
        done_hit_c = bus.MemWrite && (bus.DataAdr == DONE_ADDR);
`ifdef DMEM_ALIGN_CHECK_EN
        misalign_c = (ram_hit_c || mmio_hit_c) && (bus.DataAdr[1:0] != 2'b00);
`else
        misalign_c = 1'b0;
`endif
        ram_we_c    = bus.MemWrite && ram_hit_c && !misalign_c;
        led_we_c    = bus.MemWrite && mmio_hit_c && !misalign_c && (ofs_c == LED_OFS);
        store_err_c = bus.MemWrite && (misalign_c || (!ram_hit_c && !mmio_hit_c) ||
                      (mmio_hit_c && (ofs_c != LED_OFS) && (ofs_c != CYCLE_OFS) &&
                       (ofs_c != STATUS_OFS)));
    end

    dmem_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (ram_we_c),
        .addr  (word_idx_c),
        .wdata (bus.WriteData),
        .rdata (ram_rdata)
    );

    // Zero-latency load path
    always_comb begin
        rdata_c = '0;
        if (ram_hit_c) begin
            rdata_c = ram_rdata;
        end else if (mmio_hit_c) begin
            case (ofs_c)
                LED_OFS:    rdata_c = {24'b0, leds_q};
                CYCLE_OFS:  rdata_c = cycle_q;
                STATUS_OFS: begin
                    rdata_c[STATUS_DONE_BIT] = (state_q == DONE);
                    rdata_c[STATUS_PASS_BIT] = pass_q;
                    rdata_c[STATUS_ERR_BIT]  = err_q;
                end
                default:    rdata_c = '0;
            endcase
        end
    end

    assign bus.ReadData = rdata_c;

    // Next-state: counter, LED register, sticky error and completion FSM
    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        err_d   = err_q | store_err_c;
        leds_d  = leds_q;
        cycle_d = cycle_q + WORD_W'(1);
        if (led_we_c) begin
            leds_d = bus.WriteData[7:0];
        end
        case (state_q)
            IDLE: begin
                if (done_hit_c) begin
                    state_d = DONE;
                    pass_d  = (bus.WriteData == PASS_VALUE);
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pass_q  <= 1'b0;
            err_q   <= 1'b0;
            leds_q  <= '0;
            cycle_q <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            leds_q  <= leds_d;
            cycle_q <= cycle_d;
        end
    end

    assign leds = leds_q;
    assign done = (state_q == DONE);
    assign pass = pass_q;
    assign err  = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a queue-based scoreboard checked at the falling edge.
module tb_dmem_responder;

    localparam logic [31:0] MMIO = 32'hFFFF_FF00;
    localparam int SEL_RD  = 0;
    localparam int SEL_LED = 1;
    localparam int SEL_FLG = 2;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] leds;
    logic       done, pass, err;
    int         checks;
    int         errors;
    exp_t       sb[$];

    dmem_responder_if bus();

    dmem_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .leds  (leds),
        .done  (done),
        .pass  (pass),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic we, input logic [31:0] a,
                         input logic [31:0] d);
        @(posedge clk);
        #1;
        reset         = r;
        bus.MemWrite  = we;
        bus.DataAdr   = a;
        bus.WriteData = d;
    endtask

    task automatic expect_val(input int sel, input logic [31:0] exp, input string name);
        exp_t it;
        it.sel  = sel;
        it.exp  = exp;
        it.name = name;
        sb.push_back(it);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(1'b0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        drive(1'b0, 1'b0, a, 32'h0);
        expect_val(SEL_RD, exp, name);
    endtask

    // Monitor: every queued expectation is compared against the live outputs
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        it;
            logic [31:0] act;
            it = sb.pop_front();
            case (it.sel)
                SEL_RD:  act = bus.ReadData;
                SEL_LED: act = {24'b0, leds};
                default: act = {29'b0, err, pass, done};
            endcase
            checks++;
            if (act !== it.exp) begin
                errors++;
                $display("FAIL %s: got %08h expected %08h", it.name, act, it.exp);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        reset         = 1'b1;
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = 32'h0;
        bus.WriteData = 32'h0;

        // Two reset edges, then ten free-running cycles
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, MMIO + 32'h4, 32'h0);
        expect_val(SEL_RD, 32'd0, "cycle_at_reset");
        expect_val(SEL_FLG, 32'h0, "flags_at_reset");
        expect_val(SEL_LED, 32'h0, "leds_at_reset");
        repeat (9) drive(1'b0, 1'b0, 32'h0, 32'h0);
        rd(MMIO + 32'h4, 32'd10, "cycle_after_10");
        expect_val(SEL_FLG, 32'h0, "flags_idle");

        // RAM store and same-cycle load
        wr(32'h00, 32'h0000_0A0A);
        wr(32'h24, 32'h2424_2424);
        wr(32'h20, 32'hDEAD_BEEF);
        rd(32'h20, 32'hDEAD_BEEF, "ram_20");
        rd(32'h24, 32'h2424_2424, "ram_24_untouched");
        rd(32'h25, 32'h2424_2424, "ram_read_ignores_low_bits");

        // Completion with the pass value, then a later store that must not regrade
        wr(32'd252, 32'h0000_1000);
        rd(MMIO + 32'h8, 32'h3, "status_pass");
        expect_val(SEL_FLG, 32'h3, "flags_pass");
        wr(32'd252, 32'h0000_0005);
        rd(32'd252, 32'h0000_0005, "ram_252_second_store");
        expect_val(SEL_FLG, 32'h3, "pass_sticky");

        // Mid-run reset: flags and counter clear, RAM retained, CYCLE read-only
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        rd(MMIO + 32'h4, 32'd0, "cycle_after_reset");
        expect_val(SEL_FLG, 32'h0, "flags_after_reset");
        drive(1'b0, 1'b1, MMIO + 32'h4, 32'hFFFF_0000);
        expect_val(SEL_RD, 32'd1, "cycle_during_write");
        rd(MMIO + 32'h4, 32'd2, "cycle_write_ignored");
        expect_val(SEL_FLG, 32'h0, "cycle_write_no_err");
        rd(32'h20, 32'hDEAD_BEEF, "ram_retained");

        // Completion with a failing value
        wr(32'd252, 32'h0000_0FFF);
        rd(MMIO + 32'h8, 32'h1, "status_fail");
        expect_val(SEL_FLG, 32'h1, "flags_fail");

        // LED register, unmapped and MMIO hole reads
        wr(MMIO, 32'h1234_56A5);
        rd(MMIO, 32'h0000_00A5, "led_read");
        expect_val(SEL_LED, 32'hA5, "leds_port");
        rd(32'h0000_2000, 32'h0, "unmapped_read");
        expect_val(SEL_FLG, 32'h1, "unmapped_read_no_err");
        rd(MMIO + 32'hC, 32'h0, "mmio_hole_read");

        // Unmapped store: dropped, err set
        wr(32'h0000_2000, 32'hBAD0_BAD0);
        rd(MMIO + 32'h8, 32'h5, "status_err");
        expect_val(SEL_FLG, 32'h5, "flags_err");
        rd(32'h00, 32'h0000_0A0A, "ram_0_kept");
        rd(32'h20, 32'hDEAD_BEEF, "ram_20_kept");
        rd(32'd252, 32'h0000_0FFF, "ram_252_kept");

        // Misaligned RAM store
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        rd(MMIO, 32'h0, "led_reg_after_reset");
        expect_val(SEL_LED, 32'h0, "leds_after_reset");
        expect_val(SEL_FLG, 32'h0, "flags_clear_again");
        wr(32'h20, 32'h2020_2020);
        wr(32'h22, 32'h7777_7777);
`ifdef DMEM_ALIGN_CHECK_EN
        rd(32'h20, 32'h2020_2020, "misaligned_store_dropped");
        expect_val(SEL_FLG, 32'h4, "misaligned_err");
`else
        rd(32'h20, 32'h7777_7777, "misaligned_store_written");
        expect_val(SEL_FLG, 32'h0, "misaligned_no_err");
`endif

        // Store to an undecoded MMIO offset
        wr(MMIO + 32'h10, 32'h1);
        rd(MMIO + 32'h8, 32'h4, "status_mmio_hole_store");
        expect_val(SEL_FLG, 32'h4, "flags_mmio_hole_store");

        drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
